// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter: requester
// indices, the link register number and the buffered write entry.
package regfile_wb_pkg;

    localparam int NUM_SRC = 3;
    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_DBG = 2;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        upper;
    } wb_entry_t;

    // Value a reader would observe once the entry lands (upper writes shift up).
    function automatic logic [31:0] entry_value(input wb_entry_t e);
        return e.upper ? {e.data[15:0], 16'h0000} : e.data;
    endfunction

endpackage

// File: rtl/wb_prio_sel.sv
// Grant select for the writeback buffers: aged ALU/DBG entries first
// (ALU before DBG), otherwise fixed MEM > ALU > DBG. Entries blocked by a
// same-cycle link write are skipped so the next candidate can go.
module wb_prio_sel
    import regfile_wb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic [NUM_SRC-1:0] buf_v,
    input  logic [NUM_SRC-1:0] blocked,
    input  logic [WAIT_W-1:0]  alu_wait,
    input  logic [WAIT_W-1:0]  dbg_wait,
    output logic [NUM_SRC-1:0] grant
);

    logic [NUM_SRC-1:0] eligible;

    // One-hot grant over the eligible buffers.
    always_comb begin
        eligible = buf_v & ~blocked;
        grant    = '0;
        if (eligible[SRC_ALU] && alu_wait == WAIT_W'(MAX_WAIT)) begin
            grant[SRC_ALU] = 1'b1;
        end else if (eligible[SRC_DBG] && dbg_wait == WAIT_W'(MAX_WAIT)) begin
            grant[SRC_DBG] = 1'b1;
        end else if (eligible[SRC_MEM]) begin
            grant[SRC_MEM] = 1'b1;
        end else if (eligible[SRC_ALU]) begin
            grant[SRC_ALU] = 1'b1;
        end else if (eligible[SRC_DBG]) begin
            grant[SRC_DBG] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of register_file: one buffered write per
// requester (ALU, MEM, DBG), one general write issued per cycle, link
// writes to reg 31 never collide with a general write to reg 31.
// Optional forwarding ports are built when REGFILE_WB_FWD_EN is defined.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   req_valid,
    output logic [NUM_SRC-1:0]   req_ready,
    input  logic [5*NUM_SRC-1:0] req_addr,
    input  logic [32*NUM_SRC-1:0] req_data,
    input  logic [NUM_SRC-1:0]   req_upper,
    input  logic                 link_valid,
    input  logic [31:0]          link_data,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 rf_wren,
    output logic                 rf_is_upper,
    output logic                 rf_jal_wren,
    output logic [31:0]          rf_jal_data,
    output logic [31:0]          pending_mask,
    output logic                 busy
`ifdef REGFILE_WB_FWD_EN
    ,
    input  logic [4:0]           fwd_raddr,
    output logic                 fwd_hit,
    output logic [31:0]          fwd_data
`endif
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    wb_entry_t          buf_e [NUM_SRC];
    wb_entry_t          req_e [NUM_SRC];
    wb_entry_t          win_e;
    logic [NUM_SRC-1:0] buf_v;
    logic [NUM_SRC-1:0] blocked;
    logic [NUM_SRC-1:0] grant;
    logic [WAIT_W-1:0]  alu_wait;
    logic [WAIT_W-1:0]  dbg_wait;

    function automatic logic [WAIT_W-1:0] next_wait(input logic v, input logic g,
                                                    input logic b, input logic [WAIT_W-1:0] w);
        if (!v || g) return '0;
        if (b || w == WAIT_W'(MAX_WAIT)) return w;
        return w + 1'b1;
    endfunction

    // Unpack the request buses and flag buffers that collide with a link write.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            req_e[i]   = '{addr: req_addr[5*i +: 5], data: req_data[32*i +: 32], upper: req_upper[i]};
            blocked[i] = link_valid && buf_v[i] && (buf_e[i].addr == LINK_REG);
        end
    end

    wb_prio_sel #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_sel (
        .buf_v    (buf_v),
        .blocked  (blocked),
        .alu_wait (alu_wait),
        .dbg_wait (dbg_wait),
        .grant    (grant)
    );

    // Winning entry mux, accept handshake and scoreboard.
    always_comb begin
        win_e = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) win_e = buf_e[i];
        end
        req_ready    = ~buf_v | grant;
        busy         = |buf_v;
        pending_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (buf_v[i]) pending_mask[buf_e[i].addr] = 1'b1;
        end
        if (rf_wren) pending_mask[rf_waddr] = 1'b1;
    end

    // Buffer capture and drain; writes to reg 0 are accepted but never stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v <= '0;
            for (int i = 0; i < NUM_SRC; i++) buf_e[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (req_valid[i] && req_ready[i] && req_e[i].addr != 5'd0) begin
                    buf_v[i] <= 1'b1;
                    buf_e[i] <= req_e[i];
                end else if (grant[i]) begin
                    buf_v[i] <= 1'b0;
                end
            end
        end
    end

    // Aging counters; a link-blocked entry does not age.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_wait <= '0;
            dbg_wait <= '0;
        end else begin
            alu_wait <= next_wait(buf_v[SRC_ALU], grant[SRC_ALU], blocked[SRC_ALU], alu_wait);
            dbg_wait <= next_wait(buf_v[SRC_DBG], grant[SRC_DBG], blocked[SRC_DBG], dbg_wait);
        end
    end

    // Issue stage: general and link writes leave together, one cycle after grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wren     <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            rf_is_upper <= 1'b0;
            rf_jal_wren <= 1'b0;
            rf_jal_data <= '0;
        end else begin
            rf_wren <= |grant;
            if (|grant) begin
                rf_waddr    <= win_e.addr;
                rf_wdata    <= win_e.data;
                rf_is_upper <= win_e.upper;
            end
            rf_jal_wren <= link_valid;
            if (link_valid) rf_jal_data <= link_data;
        end
    end

`ifdef REGFILE_WB_FWD_EN
    // Forwarding lookup; later assignments take precedence (issue > MEM > ALU > DBG).
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_raddr != 5'd0) begin
            if (buf_v[SRC_DBG] && buf_e[SRC_DBG].addr == fwd_raddr) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_value(buf_e[SRC_DBG]);
            end
            if (buf_v[SRC_ALU] && buf_e[SRC_ALU].addr == fwd_raddr) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_value(buf_e[SRC_ALU]);
            end
            if (buf_v[SRC_MEM] && buf_e[SRC_MEM].addr == fwd_raddr) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_value(buf_e[SRC_MEM]);
            end
            if (rf_wren && rf_waddr == fwd_raddr) begin
                fwd_hit  = 1'b1;
                fwd_data = rf_is_upper ? {rf_wdata[15:0], 16'h0000} : rf_wdata;
            end
        end
    end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single general write port (waddr/wdata/wren/is_upper) and its dedicated link port (jal_wren/jal_data) among three writeback requesters: ALU, memory load, and debug write.
- Buffers one pending write per requester and drains at most one general write per cycle.
- Resolves the same-cycle reg-31 conflict with the link port.
- Exports a pending-write scoreboard for hazard stalls.
- Sits between the execute/memory stages and register_file.

Parameters:
- MAX_WAIT, 4, cycles a buffered ALU or debug write may lose arbitration before it is promoted to top priority.
- NUM_SRC, 3, number of requesters; fixed at 3 (0=ALU, 1=MEM, 2=DBG), used for array sizing only.

Ports:
- clk  in  1  clock; everything is on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  3  per-source write request.
- req_ready  out  3  per-source accept; high when that source's buffer is empty or draining this cycle.
- req_addr  in  15  3x5 destination register, source i at bits [5i+4:5i].
- req_data  in  96  3x32 write data.
- req_upper  in  3  per-source is_upper flag, passed through.
- link_valid  in  1  link (reg 31) write request; always accepted, never stalled.
- link_data  in  32  link value.
- rf_waddr  out  5  to register file.
- rf_wdata  out  32  to register file.
- rf_wren  out  1  to register file.
- rf_is_upper  out  1  to register file.
- rf_jal_wren  out  1  to register file.
- rf_jal_data  out  32  to register file.
- pending_mask  out  32  bit r set while any buffered write to register r is outstanding.
- busy  out  1  OR of the buffer valid bits.

Behaviour:
- Reset: all buffer valid bits, wait counters, rf_wren, rf_jal_wren and pending_mask are 0; rf_waddr/rf_wdata/rf_is_upper/rf_jal_data are 0; req_ready is 3'b111.
- Buffer accept: per source, when req_valid[i] && req_ready[i] at an edge, capture addr/data/upper and set buf_v[i].
- A request with addr==0 is accepted and discarded: no buffer set, no write issued.
- Arbitration (combinational over buf_v, registered output):
  - Any source whose wait_cnt==MAX_WAIT wins; among those, ALU before DBG.
  - Otherwise fixed priority MEM > ALU > DBG.
- Issue: the winner's entry drives rf_* on the next cycle. The outputs are registered, so a write reaches the register file one cycle after grant, and its buf_v clears at the grant edge.
- Wait counters: each non-winning valid ALU/DBG buffer increments wait_cnt, saturating at MAX_WAIT. Clear it on grant or when the buffer is empty. MEM has no counter.
- Same-cycle refill: req_ready[i] is high when buf_v[i]==0 or source i is granted this cycle, so a new request is accepted the same edge the old one drains.
- Link port: link_valid registers to rf_jal_wren/rf_jal_data with one-cycle latency, in the same stage as rf_wren.
  - If the arbitration winner targets reg 31 in a cycle where link_valid=1, the grant is suppressed that cycle.
  - The entry stays buffered, its wait counter does not increment, and the next candidate in priority order is granted instead.
  - Result: register_file never sees wren and jal_wren on reg 31 together.
- pending_mask: set bit for each valid buffer's addr plus the in-flight rf_waddr stage; cleared after the register file write edge. Two sources targeting the same register keep the bit set until both have written.
- Ordering: no ordering is guaranteed between different sources to the same register; the pipeline must stall on pending_mask. The same source is naturally in order.
- Reset mid-operation: buffered writes are dropped, and no write is issued on the cycle after reset.

Optional Feature:
- REGFILE_WB_FWD_EN: adds ports fwd_raddr in 5, fwd_hit out 1, fwd_data out 32.
  - fwd_hit is combinationally set when a valid buffer or the issue stage holds a write to fwd_raddr≠0.
  - fwd_data gives the issue stage first, then the buffers in MEM>ALU>DBG order, with the is_upper shift (data<<16) applied.
- Without the macro these ports do not exist and no forwarding logic is built.

Decomposition:
- Package regfile_wb_pkg: source index constants SRC_ALU=0, SRC_MEM=1, SRC_DBG=2; LINK_REG=31; a write-entry typedef {addr[4:0], data[31:0], upper}.
- Sub-module wb_prio_sel: priority/aging select over buf_v, wait_cnt and the link-conflict mask; outputs a one-hot grant.

Test Plan:
- ALU alone: req addr=5 data=0x1234 -> rf_wren=1, waddr=5, wdata=0x1234 one cycle after accept; pending_mask[5] set, then cleared.
- ALU, MEM and DBG all valid in one cycle (addrs 1,2,3) -> issue order MEM(2), ALU(1), DBG(3) on 3 consecutive cycles; req_ready for ALU/DBG low while held.
- MEM requests every cycle with DBG waiting, MAX_WAIT=4 -> DBG granted on the 5th cycle after buffering, then MEM resumes.
- link_valid=1 with ALU write to 31 in the same cycle -> rf_jal_wren=1 data=link, rf_wren=0 that cycle; ALU write to 31 issues the following cycle.
- req addr=0 -> accepted, rf_wren stays 0, pending_mask unchanged.
- Assert rst with all three buffers full -> next cycle rf_wren=0, busy=0, pending_mask=0, req_ready=3'b111.
